// File: rtl/seg_pkg.sv
// Purpose: shared glyph codes and segment constants for the 7-segment scan driver.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg_pkg;

  // Glyph codes accepted on the per-digit code bus.
  localparam logic [4:0] GLYPH_ZERO   = 5'h00;
  localparam logic [4:0] GLYPH_DOT    = 5'h0A;
  localparam logic [4:0] GLYPH_B      = 5'h0B;
  localparam logic [4:0] GLYPH_C      = 5'h0C;
  localparam logic [4:0] GLYPH_D      = 5'h0D;
  localparam logic [4:0] GLYPH_HEX_E  = 5'h0E;
  localparam logic [4:0] GLYPH_BLANK  = 5'h0F;
  localparam logic [4:0] GLYPH_E      = 5'h10;
  localparam logic [4:0] GLYPH_R      = 5'h11;
  localparam logic [4:0] GLYPH_R_DOT  = 5'h12;
  localparam logic [4:0] GLYPH_T      = 5'h13;
  localparam logic [4:0] GLYPH_O      = 5'h14;
  localparam logic [4:0] GLYPH_U      = 5'h15;
  localparam logic [4:0] GLYPH_H      = 5'h16;
  localparam logic [4:0] GLYPH_D_ALT  = 5'h17;

  // Active-low segment pattern with every segment off, {dp,g,f,e,d,c,b,a}.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg_glyph_decode.sv
// Purpose: 5-bit glyph code to active-low 7-segment pattern; sole owner of the glyph table.
// Latency: combinational.
// Backpressure: none.
// Ports: code (glyph code in), pattern ({dp,g,f,e,d,c,b,a}, active low, out).
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [4:0] code,
  output logic [7:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (code)
      5'h00:       pattern = 8'hC0;
      5'h01:       pattern = 8'hF9;
      5'h02:       pattern = 8'hA4;
      5'h03:       pattern = 8'hB0;
      5'h04:       pattern = 8'h99;
      5'h05:       pattern = 8'h92;
      5'h06:       pattern = 8'h82;
      5'h07:       pattern = 8'hF8;
      5'h08:       pattern = 8'h80;
      5'h09:       pattern = 8'h90;
      GLYPH_DOT:   pattern = 8'h7F;
      GLYPH_B:     pattern = 8'h83;
      GLYPH_C:     pattern = 8'hC6;
      GLYPH_D:     pattern = 8'hA1;
      GLYPH_HEX_E: pattern = 8'h86;
      GLYPH_BLANK: pattern = SEG_BLANK;
      GLYPH_E:     pattern = 8'h86;
      GLYPH_R:     pattern = 8'h8F;
      GLYPH_R_DOT: pattern = 8'h0F;
      GLYPH_T:     pattern = 8'h87;
      GLYPH_O:     pattern = 8'hA3;
      GLYPH_U:     pattern = 8'hE3;
      GLYPH_H:     pattern = 8'h89;
      GLYPH_D_ALT: pattern = 8'hA1;
      default:     pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Purpose: time-multiplexed N-digit common-anode 7-segment driver with per-frame input snapshot.
// Latency: an/seg registered one cycle after prescaler/index state; snapshot visible from slot 0 of its frame.
// Backpressure: none; enable=0 freezes counters and darkens the display.
// Ports: clk, reset (sync, active high), enable, codes (5b per digit), dp/blank/blink masks,
//        an (active-low anodes), seg (active-low {dp,g..a}), frame_start (snapshot pulse).
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int DEAD_CYC     = 2,
  parameter int BLINK_FRAMES = 250,
  parameter int LZ_SUPPRESS  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [5*NUM_DIGITS-1:0] codes,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic                    frame_start
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [PW-1:0]         PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]         PRE_DEAD = PW'(DEAD_CYC);
  localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0]         BLK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [BW-1:0]         blk_cnt;
  logic                  blink_off;
  logic                  first_pending;   // no snapshot taken yet since reset

  logic [4:0]            sh_codes [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] sh_dp;
  logic [NUM_DIGITS-1:0] sh_blank;
  logic [NUM_DIGITS-1:0] sh_blink;
  logic [NUM_DIGITS-1:0] sh_lz;

  logic [NUM_DIGITS-1:0] lz_next;
  logic                  leading;
  logic                  tick;
  logic                  wrap;
  logic                  visible;
  logic [7:0]            glyph;

  // Leading-zero mask of the incoming codes: a digit is suppressed only if it
  // and every digit above it are 0x00. Digit 0 always shows.
  always_comb begin
    lz_next = '0;
    leading = 1'b1;
    if (LZ_SUPPRESS != 0) begin
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        if (codes[5*i +: 5] != GLYPH_ZERO) leading = 1'b0;
        lz_next[i] = leading;
      end
    end
  end

  assign tick        = enable && (presc == PRE_LAST);
  assign wrap        = tick && (idx == IDX_LAST);
  assign frame_start = !reset && enable && (first_pending || wrap);

  assign visible = !sh_blank[idx] && !sh_lz[idx] && !(blink_off && sh_blink[idx])
                   && (presc >= PRE_DEAD);

  seg_glyph_decode u_decode (
    .code    (sh_codes[idx]),
    .pattern (glyph)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      presc         <= '0;
      idx           <= '0;
      blk_cnt       <= '0;
      blink_off     <= 1'b0;
      first_pending <= 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) sh_codes[i] <= GLYPH_BLANK;
      sh_dp         <= '0;
      sh_blank      <= '0;
      sh_blink      <= '0;
      sh_lz         <= '0;
      an            <= '1;
      seg           <= SEG_BLANK;
    end else begin
      if (frame_start) begin
        for (int i = 0; i < NUM_DIGITS; i++) sh_codes[i] <= codes[5*i +: 5];
        sh_dp         <= dp_mask;
        sh_blank      <= blank_mask;
        sh_blink      <= blink_mask;
        sh_lz         <= lz_next;
        first_pending <= 1'b0;
      end

      if (enable) begin
        if (tick) begin
          presc <= '0;
          idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
          presc <= presc + PW'(1);
        end

        if (wrap) begin
          if (blk_cnt == BLK_LAST) begin
            blk_cnt   <= '0;
            blink_off <= !blink_off;
          end else begin
            blk_cnt <= blk_cnt + BW'(1);
          end
        end
      end

      // Outputs follow the pre-edge counter state, giving the one-cycle lag.
      if (enable && visible) begin
        an  <= ~(AN_ONE << idx);
        seg <= glyph & ~{sh_dp[idx], 7'b0};
      end else begin
        an  <= '1;
        seg <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Purpose: directed self-checking bench for seg_scan_driver (4 digits, 8-cycle slots).
// Latency: n/a.
// Backpressure: n/a.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [19:0] codes;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_start;
  logic [3:0]  lz_an;
  logic [7:0]  lz_seg;
  logic        lz_frame_start;

  int ntests = 0;
  int nfail  = 0;
  int opos   = 0;   // frame position whose state produced the current an/seg

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .DEAD_CYC(2), .BLINK_FRAMES(2), .LZ_SUPPRESS(0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .codes(codes),
    .dp_mask(dp_mask), .blank_mask(blank_mask), .blink_mask(blink_mask),
    .an(an), .seg(seg), .frame_start(frame_start)
  );

  seg_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .DEAD_CYC(2), .BLINK_FRAMES(2), .LZ_SUPPRESS(1)
  ) dut_lz (
    .clk(clk), .reset(reset), .enable(enable), .codes(codes),
    .dp_mask(dp_mask), .blank_mask(blank_mask), .blink_mask(blink_mask),
    .an(lz_an), .seg(lz_seg), .frame_start(lz_frame_start)
  );

  // Advance enabled clock edges until the outputs reflect position target.
  task automatic run_to(input int target);
    int guard = 0;
    while (opos < target && guard < 4000) begin
      @(posedge clk); #1;
      opos++;
      guard++;
    end
  endtask

  task automatic release_reset();
    reset  = 1'b0;
    enable = 1'b1;
    opos   = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    codes = {5'h03, 5'h02, 5'h01, 5'h00};
    dp_mask = '0; blank_mask = '0; blink_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    ntests++;
    if ({an, seg, frame_start} !== {4'hF, 8'hFF, 1'b0}) begin
      nfail++;
      $display("FAIL reset_out got an=%b seg=%h fs=%b want an=1111 seg=ff fs=0", an, seg, frame_start);
    end
    ntests++;
    if ({lz_an, lz_seg} !== {4'hF, 8'hFF}) begin
      nfail++;
      $display("FAIL reset_lz got an=%b seg=%h want an=1111 seg=ff", lz_an, lz_seg);
    end
    release_reset();
    #1;
    ntests++;
    if (frame_start !== 1'b1) begin
      nfail++;
      $display("FAIL first_fs got %b want 1", frame_start);
    end
    run_to(0);
    ntests++;
    if ({an, seg, frame_start} !== {4'hF, 8'hFF, 1'b0}) begin
      nfail++;
      $display("FAIL first_cycle got an=%b seg=%h fs=%b want an=1111 seg=ff fs=0", an, seg, frame_start);
    end
  endtask

  task automatic test_scan();
    logic [3:0] exp_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] exp_seg [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
    for (int s = 0; s < 4; s++) begin
      run_to(s * 8 + 1);
      ntests++;
      if ({an, seg} !== {4'hF, 8'hFF}) begin
        nfail++;
        $display("FAIL scan_dead slot%0d got an=%b seg=%h want an=1111 seg=ff", s, an, seg);
      end
      run_to(s * 8 + 2);
      ntests++;
      if ({an, seg} !== {exp_an[s], exp_seg[s]}) begin
        nfail++;
        $display("FAIL scan_lit slot%0d got an=%b seg=%h want an=%b seg=%h", s, an, seg, exp_an[s], exp_seg[s]);
      end
      run_to(s * 8 + 7);
      ntests++;
      if ({an, seg} !== {exp_an[s], exp_seg[s]}) begin
        nfail++;
        $display("FAIL scan_end slot%0d got an=%b seg=%h want an=%b seg=%h", s, an, seg, exp_an[s], exp_seg[s]);
      end
      if (s == 3) begin
        // s*8+7 = 31 was just passed; check pulse placement inside frame 1
        run_to(32 + 29);
        ntests++;
        if (frame_start !== 1'b0) begin
          nfail++;
          $display("FAIL fs_early got %b want 0", frame_start);
        end
        run_to(32 + 30);
        ntests++;
        if (frame_start !== 1'b1) begin
          nfail++;
          $display("FAIL fs_wrap got %b want 1", frame_start);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    // Frame 1 already snapshotted {3,2,1,0}; change codes now (frame 1 end) and
    // again mid frame 2 to confirm the frame-2 snapshot is taken at its start.
    logic [3:0] exp_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] exp_new [4] = '{8'h86, 8'h8F, 8'h87, 8'h99};
    codes = {5'h04, 5'h13, 5'h11, 5'h0E};
    run_to(64 + 2);
    ntests++;
    if ({an, seg} !== {exp_an[0], exp_new[0]}) begin
      nfail++;
      $display("FAIL snap_new slot0 got an=%b seg=%h want an=%b seg=%h", an, seg, exp_an[0], exp_new[0]);
    end
    codes = {5'h09, 5'h09, 5'h09, 5'h09};   // mid-frame change must stay hidden
    for (int s = 1; s < 4; s++) begin
      run_to(64 + s * 8 + 2);
      ntests++;
      if ({an, seg} !== {exp_an[s], exp_new[s]}) begin
        nfail++;
        $display("FAIL snap_hold slot%0d got an=%b seg=%h want an=%b seg=%h", s, an, seg, exp_an[s], exp_new[s]);
      end
    end
  endtask

  task automatic test_dp_glyphs();
    logic [7:0] exp_dp [4] = '{8'h92, 8'h12, 8'h92, 8'h92};
    logic [3:0] exp_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] exp_gl [4] = '{8'h89, 8'h7F, 8'h0F, 8'hFF};
    codes = {5'h05, 5'h05, 5'h05, 5'h05};
    dp_mask = 4'b0010;
    for (int s = 0; s < 4; s++) begin
      run_to(96 + s * 8 + 3);
      ntests++;
      if ({an, seg} !== {exp_an[s], exp_dp[s]}) begin
        nfail++;
        $display("FAIL dp slot%0d got an=%b seg=%h want an=%b seg=%h", s, an, seg, exp_an[s], exp_dp[s]);
      end
    end
    codes = {5'h1F, 5'h12, 5'h0A, 5'h16};
    dp_mask = 4'b0000;
    for (int s = 0; s < 4; s++) begin
      run_to(128 + s * 8 + 3);
      ntests++;
      if ({an, seg} !== {exp_an[s], exp_gl[s]}) begin
        nfail++;
        $display("FAIL glyph slot%0d got an=%b seg=%h want an=%b seg=%h", s, an, seg, exp_an[s], exp_gl[s]);
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [3:0] exp_an  [4] = '{4'hE, 4'hD, 4'hF, 4'hF};
    logic [7:0] exp_seg [4] = '{8'hC0, 8'h99, 8'hFF, 8'hFF};
    codes = {5'h00, 5'h00, 5'h04, 5'h00};
    for (int s = 0; s < 4; s++) begin
      run_to(160 + s * 8 + 4);
      ntests++;
      if ({lz_an, lz_seg} !== {exp_an[s], exp_seg[s]}) begin
        nfail++;
        $display("FAIL lz slot%0d got an=%b seg=%h want an=%b seg=%h", s, lz_an, lz_seg, exp_an[s], exp_seg[s]);
      end
    end
    // Without suppression the leading zero is shown.
    ntests++;
    if ({an, seg} !== {4'h7, 8'hC0}) begin
      nfail++;
      $display("FAIL no_lz slot3 got an=%b seg=%h want an=0111 seg=c0", an, seg);
    end
    codes = {5'h08, 5'h08, 5'h08, 5'h08};
    blank_mask = 4'b0100;
    run_to(192 + 8 + 4);
    ntests++;
    if ({an, seg} !== {4'hD, 8'h80}) begin
      nfail++;
      $display("FAIL blank_other got an=%b seg=%h want an=1101 seg=80", an, seg);
    end
    run_to(192 + 16 + 4);
    ntests++;
    if ({an, seg} !== {4'hF, 8'hFF}) begin
      nfail++;
      $display("FAIL blank_dig2 got an=%b seg=%h want an=1111 seg=ff", an, seg);
    end
  endtask

  task automatic test_blink();
    logic       lit [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [11:0] want;
    reset = 1'b1;
    codes = {5'h01, 5'h02, 5'h03, 5'h04};
    blank_mask = '0;
    blink_mask = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    release_reset();
    for (int f = 0; f < 6; f++) begin
      run_to(f * 32 + 4);
      want = lit[f] ? {4'hE, 8'h99} : {4'hF, 8'hFF};
      ntests++;
      if ({an, seg} !== want) begin
        nfail++;
        $display("FAIL blink_d0 frame%0d got an=%b seg=%h want %h", f, an, seg, want);
      end
      run_to(f * 32 + 12);
      ntests++;
      if ({an, seg} !== {4'hD, 8'hB0}) begin
        nfail++;
        $display("FAIL blink_d1 frame%0d got an=%b seg=%h want an=1101 seg=b0", f, an, seg);
      end
    end
  endtask

  task automatic test_enable_reset();
    run_to(203);                       // current state: slot 1, prescaler 4
    enable = 1'b0;
    codes = {5'h08, 5'h08, 5'h08, 5'h08};
    @(posedge clk); #1;
    ntests++;
    if ({an, seg, frame_start} !== {4'hF, 8'hFF, 1'b0}) begin
      nfail++;
      $display("FAIL dis_dark got an=%b seg=%h fs=%b want an=1111 seg=ff fs=0", an, seg, frame_start);
    end
    repeat (9) @(posedge clk);
    #1;
    ntests++;
    if ({an, seg} !== {4'hF, 8'hFF}) begin
      nfail++;
      $display("FAIL dis_hold got an=%b seg=%h want an=1111 seg=ff", an, seg);
    end
    enable = 1'b1;
    opos = 203;
    run_to(204);
    ntests++;
    if ({an, seg} !== {4'hD, 8'hB0}) begin
      nfail++;
      $display("FAIL reen_resume got an=%b seg=%h want an=1101 seg=b0", an, seg);
    end
    run_to(209);
    ntests++;
    if ({an, seg} !== {4'hF, 8'hFF}) begin
      nfail++;
      $display("FAIL reen_dead got an=%b seg=%h want an=1111 seg=ff", an, seg);
    end
    run_to(210);
    ntests++;
    if ({an, seg} !== {4'hB, 8'hA4}) begin
      nfail++;
      $display("FAIL reen_nosnap got an=%b seg=%h want an=1011 seg=a4", an, seg);
    end
    run_to(213);
    reset = 1'b1;
    @(posedge clk); #1;
    ntests++;
    if ({an, seg} !== {4'hF, 8'hFF}) begin
      nfail++;
      $display("FAIL midreset_dark got an=%b seg=%h want an=1111 seg=ff", an, seg);
    end
    release_reset();
    run_to(2);
    ntests++;
    if ({an, seg} !== {4'hE, 8'h80}) begin
      nfail++;
      $display("FAIL midreset_idx0 got an=%b seg=%h want an=1110 seg=80", an, seg);
    end
    run_to(10);
    ntests++;
    if ({an, seg} !== {4'hD, 8'h80}) begin
      nfail++;
      $display("FAIL midreset_idx1 got an=%b seg=%h want an=1101 seg=80", an, seg);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; codes = '0;
    dp_mask = '0; blank_mask = '0; blink_mask = '0;
    test_reset();
    test_scan();
    test_snapshot();
    test_dp_glyphs();
    test_lz_blank();
    test_blink();
    test_enable_reset();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
